// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage memory access unit.
// Pure declarations, no timing.
// No flow control here; users own all handshaking.
package mem_pkg;

    // Access sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // funct3 access size / signedness encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Store byte-enable patterns before shifting by the byte offset
    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Halves must sit on even addresses, words on multiples of four.
    // Byte and reserved codes never fault.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load formatter: picks the addressed byte/half from the aligned word and extends it.
// Purely combinational, zero latency.
// No backpressure; output follows inputs.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the lane and apply sign or zero extension by funct3
    always_comb begin
        case (offset_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data_o = {24'd0, byte_v};
            F3_H:    data_o = {{16{half_v[15]}}, half_v};
            F3_HU:   data_o = {16'd0, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one cache request per access and formats load data.
// Load: 3 stall cycles minimum (IDLE, REQ, WAIT) then DONE; store: 2 (IDLE, REQ) then DONE.
// Holds the pipeline via stallM while reqReady is low or the response is pending; build with
// MEM_STALL_CNT_EN to add the stallCycles performance counter output.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic [2:0]        funct3M,
    input  logic [ADDR_W-1:0] aluResultM,
    input  logic [DATA_W-1:0] writeDataM,
    output logic [DATA_W-1:0] readDataM,
    output logic              stallM,
    output logic              misalignM,
    output logic              reqValid,
    input  logic              reqReady,
    output logic              reqWrite,
    output logic [ADDR_W-1:0] reqAddr,
    output logic [DATA_W-1:0] reqWdata,
    output logic [3:0]        reqByteEn,
    input  logic              rspValid,
    input  logic [DATA_W-1:0] rspRdata
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stallCycles
`endif
);

    state_t            state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic              reqValid_q;
    logic              reqWrite_q;
    logic [ADDR_W-1:0] reqAddr_q;
    logic [DATA_W-1:0] reqWdata_q;
    logic [3:0]        reqByteEn_q;
    logic [DATA_W-1:0] readData_q;

    logic              op;
    logic              misaligned;
    logic [1:0]        offset;
    logic [3:0]        byteEn_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] loadFmt;

    assign offset     = aluResultM[1:0];
    assign op         = memReadM | memWriteM;
    assign misaligned = is_misaligned(funct3M, offset);

    // Store lane replication and byte enables, evaluated against the instruction in IDLE
    always_comb begin
        byteEn_d = BE_W;
        wdata_d  = writeDataM;
        case (funct3M)
            F3_B: begin
                byteEn_d = BE_B << offset;
                wdata_d  = {4{writeDataM[7:0]}};
            end
            F3_H: begin
                byteEn_d = BE_H << offset;
                wdata_d  = {2{writeDataM[15:0]}};
            end
            default: begin
                byteEn_d = BE_W;
                wdata_d  = writeDataM;
            end
        endcase
    end

    load_extend u_load_extend (
        .word_i   (rspRdata),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_o   (loadFmt)
    );

    // Access sequencer with registered cache request and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            funct3_q    <= 3'd0;
            offset_q    <= 2'd0;
            reqValid_q  <= 1'b0;
            reqWrite_q  <= 1'b0;
            reqAddr_q   <= '0;
            reqWdata_q  <= '0;
            reqByteEn_q <= 4'd0;
            readData_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op) begin
                        if (misaligned) begin
                            // Faulting access is dropped; clear the result so nothing stale is consumed
                            readData_q <= '0;
                        end else begin
                            funct3_q    <= funct3M;
                            offset_q    <= offset;
                            reqValid_q  <= 1'b1;
                            // Read+write together resolves to a store
                            reqWrite_q  <= memWriteM;
                            reqAddr_q   <= {aluResultM[ADDR_W-1:2], 2'b00};
                            reqWdata_q  <= memWriteM ? wdata_d : '0;
                            reqByteEn_q <= memWriteM ? byteEn_d : 4'd0;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (reqReady) begin
                        reqValid_q <= 1'b0;
                        state_q    <= reqWrite_q ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (rspValid) begin
                        readData_q <= loadFmt;
                        state_q    <= DONE;
                    end
                end
                default: begin
                    // DONE: pipeline advances this edge; next instruction is seen in IDLE
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall and fault flags react to the current instruction while idle
    always_comb begin
        stallM    = 1'b0;
        misalignM = 1'b0;
        if (!rst) begin
            stallM    = ((state_q == IDLE) && op && !misaligned) ||
                        (state_q == REQ) || (state_q == WAIT);
            misalignM = (state_q == IDLE) && op && misaligned;
        end
    end

    assign readDataM = readData_q;
    assign reqValid  = reqValid_q;
    assign reqWrite  = reqWrite_q;
    assign reqAddr   = reqAddr_q;
    assign reqWdata  = reqWdata_q;
    assign reqByteEn = reqByteEn_q;

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stallCnt_q;

    // Free-running count of stalled cycles, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= 32'd0;
        end else if (stallM) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stallCycles = stallCnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a timeline model of each access.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Optional stallCycles output is checked when MEM_STALL_CNT_EN is defined.
module tb_mem_access_unit;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk, rst;
    logic        memReadM, memWriteM;
    logic [2:0]  funct3M;
    logic [31:0] aluResultM, writeDataM, readDataM;
    logic        stallM, misalignM, reqValid, reqReady, reqWrite;
    logic [31:0] reqAddr, reqWdata, rspRdata;
    logic [3:0]  reqByteEn;
    logic        rspValid;
`ifdef MEM_STALL_CNT_EN
    logic [31:0] stallCycles;
`endif

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [31:0] model_rd = 32'd0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .memReadM   (memReadM),
        .memWriteM  (memWriteM),
        .funct3M    (funct3M),
        .aluResultM (aluResultM),
        .writeDataM (writeDataM),
        .readDataM  (readDataM),
        .stallM     (stallM),
        .misalignM  (misalignM),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqWrite   (reqWrite),
        .reqAddr    (reqAddr),
        .reqWdata   (reqWdata),
        .reqByteEn  (reqByteEn),
        .rspValid   (rspValid),
        .rspRdata   (rspRdata)
`ifdef MEM_STALL_CNT_EN
        ,
        .stallCycles(stallCycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int load_size(input logic [2:0] f3);
        if (f3 == LH || f3 == LHU) return 2;
        if (f3 == LW) return 4;
        return 1;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (a % load_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
        int off = int'(a[1:0]);
        int hsel = int'(a[1]);
        logic [7:0] b = w[8*off +: 8];
        logic [15:0] h = w[16*hsel +: 16];
        logic [31:0] r;
        case (f3)
            LB:  begin r = {24'd0, b}; if (b >= 8'd128) r = r - 32'd256; end
            LBU: r = {24'd0, b};
            LH:  begin r = {16'd0, h}; if (h >= 16'd32768) r = r - 32'd65536; end
            LHU: r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic int store_size(input logic [2:0] f3);
        if (f3 == 3'b000) return 1;
        if (f3 == 3'b001) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = store_size(f3);
        int v;
        if (n == 4) return 4'hF;
        v = ((1 << n) - 1) << int'(a[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n = store_size(f3);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    // One access, checked against its expected timeline every cycle.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int rdly, input int sdly,
                          input bit idle,
                          output logic [31:0] rd_out, output logic [3:0] be_seen,
                          output logic [31:0] wd_seen, output logic [31:0] addr_seen,
                          output int stall_seen);
        logic mis, is_st, in_req, in_wait, done, exp_stall;
        logic [31:0] exp_done;
        int n, rspk;
        is_st = wr;
        mis = m_mis(f3, addr);
        n = mis ? 1 : (is_st ? 3 + rdly : 4 + rdly + sdly);
        rspk = 2 + rdly + sdly;
        exp_done = is_st ? model_rd : m_load(rdata, addr, f3);
        rd_out = 32'd0; be_seen = 4'd0; wd_seen = 32'd0; addr_seen = 32'd0; stall_seen = 0;
        memReadM = rd; memWriteM = wr; funct3M = f3; aluResultM = addr; writeDataM = wdata;
        for (int k = 0; k < n; k++) begin
            in_req = !mis && k >= 1 && k <= 1 + rdly;
            in_wait = !mis && !is_st && k >= 2 + rdly && k <= rspk;
            done = !mis && k == n - 1;
            exp_stall = !mis && !done;
            reqReady = in_req && k == 1 + rdly;
            // real response in WAIT; junk pulses elsewhere must be ignored
            rspValid = (in_wait && k == rspk) || (is_st && in_req) || done;
            rspRdata = (in_wait && k == rspk) ? rdata : 32'hA5A55A5A;
            @(negedge clk);
            chk("stallM", {31'd0, stallM}, {31'd0, exp_stall});
            chk("misalignM", {31'd0, misalignM}, {31'd0, mis && k == 0});
            chk("reqValid", {31'd0, reqValid}, {31'd0, in_req});
            if (in_req) begin
                chk("reqAddr", reqAddr, {addr[31:2], 2'b00});
                chk("reqWrite", {31'd0, reqWrite}, {31'd0, is_st});
                chk("reqByteEn", {28'd0, reqByteEn}, {28'd0, is_st ? m_be(f3, addr) : 4'd0});
                if (is_st) chk("reqWdata", reqWdata, m_wdata(f3, wdata));
                be_seen = reqByteEn; wd_seen = reqWdata; addr_seen = reqAddr;
            end
            chk("readDataM", readDataM, done ? exp_done : model_rd);
            if (done) rd_out = readDataM;
`ifdef MEM_STALL_CNT_EN
            chk("stallCycles", stallCycles, exp_cnt);
`endif
            if (stallM) stall_seen++;
            if (exp_stall) exp_cnt++;
            @(posedge clk); #1;
        end
        model_rd = mis ? 32'd0 : exp_done;
        memReadM = 1'b0; memWriteM = 1'b0; reqReady = 1'b0; rspValid = 1'b0;
        if (idle) begin
            @(negedge clk);
            chk("idle_readDataM", readDataM, model_rd);
            chk("idle_stallM", {31'd0, stallM}, 32'd0);
            chk("idle_reqValid", {31'd0, reqValid}, 32'd0);
            if (mis) rd_out = readDataM;
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] r, wd, ad;
    logic [3:0]  be;
    int          st;

    initial begin
        // reset with live inputs and a stale response present
        rst = 1'b1; memReadM = 1'b1; memWriteM = 1'b0; funct3M = LW; aluResultM = 32'h101;
        writeDataM = 32'h12345678; reqReady = 1'b1; rspValid = 1'b1; rspRdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rst_stallM", {31'd0, stallM}, 32'd0);
        chk("rst_misalignM", {31'd0, misalignM}, 32'd0);
        chk("rst_reqValid", {31'd0, reqValid}, 32'd0);
        chk("rst_reqWrite", {31'd0, reqWrite}, 32'd0);
        chk("rst_reqAddr", reqAddr, 32'd0);
        chk("rst_reqWdata", reqWdata, 32'd0);
        chk("rst_reqByteEn", {28'd0, reqByteEn}, 32'd0);
        chk("rst_readDataM", readDataM, 32'd0);
`ifdef MEM_STALL_CNT_EN
        chk("rst_stallCycles", stallCycles, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0; memReadM = 1'b0; reqReady = 1'b0;
        @(negedge clk);
        chk("stale_rsp_readDataM", readDataM, 32'd0);
        chk("stale_rsp_stallM", {31'd0, stallM}, 32'd0);
        @(posedge clk); #1;
        rspValid = 1'b0;

        access(1, 0, LW, 32'h100, 0, 32'hDEADBEEF, 0, 0, 1, r, be, wd, ad, st);
        chk("lw_data", r, 32'hDEADBEEF);
        chk("lw_stall", st, 3);
        chk("lw_addr", ad, 32'h100);
        access(1, 0, LB, 32'h203, 0, 32'h80FF1234, 0, 0, 1, r, be, wd, ad, st);
        chk("lb_data", r, 32'hFFFFFF80);
        access(1, 0, LBU, 32'h203, 0, 32'h80FF1234, 0, 0, 1, r, be, wd, ad, st);
        chk("lbu_data", r, 32'h00000080);
        access(1, 0, LHU, 32'h202, 0, 32'h80FF1234, 0, 0, 1, r, be, wd, ad, st);
        chk("lhu_data", r, 32'h000080FF);
        access(1, 0, LH, 32'h202, 0, 32'h80FF1234, 0, 0, 1, r, be, wd, ad, st);
        chk("lh_data", r, 32'hFFFF80FF);
        access(1, 0, LB, 32'h200, 0, 32'h80FF1234, 0, 0, 1, r, be, wd, ad, st);
        chk("lb_pos_data", r, 32'h00000034);

        access(0, 1, LH, 32'h302, 32'h0000ABCD, 0, 2, 0, 1, r, be, wd, ad, st);
        chk("sh_be", {28'd0, be}, 32'hC);
        chk("sh_wdata", wd, 32'hABCDABCD);
        chk("sh_stall", st, 4);
        chk("sh_addr", ad, 32'h300);
        chk("sh_keeps_rd", r, 32'h00000034);
        access(0, 1, LB, 32'h101, 32'h12345678, 0, 0, 0, 1, r, be, wd, ad, st);
        chk("sb_be", {28'd0, be}, 32'h2);
        chk("sb_wdata", wd, 32'h78787878);
        access(0, 1, LW, 32'h204, 32'hCAFEF00D, 0, 1, 0, 1, r, be, wd, ad, st);
        chk("sw_be", {28'd0, be}, 32'hF);
        chk("sw_stall", st, 3);
        access(1, 1, LW, 32'h10, 32'h11223344, 32'h99999999, 0, 0, 1, r, be, wd, ad, st);
        chk("rdwr_as_store_stall", st, 2);
        chk("rdwr_keeps_rd", r, 32'h00000034);
        access(1, 0, LW, 32'h108, 0, 32'h01234567, 1, 2, 1, r, be, wd, ad, st);
        chk("lw_delay_stall", st, 6);
        chk("lw_delay_data", r, 32'h01234567);

        access(1, 0, LW, 32'h101, 0, 0, 0, 0, 1, r, be, wd, ad, st);
        chk("lw_mis_rd", r, 32'd0);
        chk("lw_mis_stall", st, 0);
        access(1, 0, LW, 32'h120, 0, 32'h55AA55AA, 0, 0, 1, r, be, wd, ad, st);
        access(0, 1, LW, 32'h102, 32'h1, 0, 0, 0, 1, r, be, wd, ad, st);
        chk("sw_mis_rd", r, 32'd0);
        access(1, 0, LW, 32'h124, 0, 32'h76543210, 0, 0, 1, r, be, wd, ad, st);
        access(1, 0, LH, 32'h203, 0, 0, 0, 0, 1, r, be, wd, ad, st);
        chk("lh_mis_rd", r, 32'd0);
        access(1, 0, LHU, 32'h201, 0, 0, 0, 0, 1, r, be, wd, ad, st);

        // load in flight, reset asserted while waiting for the response
        access(1, 0, LW, 32'h130, 0, 32'h0BADF00D, 0, 0, 1, r, be, wd, ad, st);
        memReadM = 1'b1; funct3M = LW; aluResultM = 32'h400;
        @(posedge clk); #1;
        reqReady = 1'b1;
        @(posedge clk); #1;
        reqReady = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_stallM", {31'd0, stallM}, 32'd0);
        chk("rstwait_reqValid", {31'd0, reqValid}, 32'd0);
        chk("rstwait_readDataM", readDataM, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; memReadM = 1'b0; rspValid = 1'b1; rspRdata = 32'h11111111;
        @(negedge clk);
        chk("late_rsp_stallM", {31'd0, stallM}, 32'd0);
        chk("late_rsp_reqValid", {31'd0, reqValid}, 32'd0);
        @(posedge clk); #1;
        rspValid = 1'b0;
        @(negedge clk);
        chk("late_rsp_readDataM", readDataM, 32'd0);
        @(posedge clk); #1;
        model_rd = 32'd0;
        exp_cnt = 0;

        // back-to-back load then store straight after reset
        access(1, 0, LW, 32'h500, 0, 32'hFEEDFACE, 0, 0, 0, r, be, wd, ad, st);
        chk("b2b_lw_data", r, 32'hFEEDFACE);
        access(0, 1, LW, 32'h504, 32'h5, 0, 0, 0, 1, r, be, wd, ad, st);
`ifdef MEM_STALL_CNT_EN
        chk("stall_count_5", stallCycles, 32'd5);
`endif
        chk("b2b_rd_kept", readDataM, 32'hFEEDFACE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
